// File: rtl/main_mem_port_arbiter.sv
// Main-memory port arbiter: fetch / memory stage / loader share one port.
// Ports: fetch_* (read), data_* (load/store), ldr_* (write), mem_* (memory),
//   fetch_starved (starvation override active). clk, rst (async, low).
module main_mem_port_arbiter #(
  parameter int LATENCY      = 1,
  parameter int STARVE_LIMIT = 4,
  parameter int DEPTH_BITS   = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_req,
  input  logic [31:0]           fetch_addr,
  output logic                  fetch_gnt,
  output logic                  fetch_rvalid,
  output logic [31:0]           fetch_rdata,
  input  logic                  data_req,
  input  logic                  data_we,
  input  logic [31:0]           data_addr,
  input  logic [31:0]           data_wdata,
  output logic                  data_gnt,
  output logic                  data_rvalid,
  output logic [31:0]           data_rdata,
  input  logic                  ldr_req,
  input  logic [31:0]           ldr_addr,
  input  logic [31:0]           ldr_wdata,
  output logic                  ldr_gnt,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [DEPTH_BITS-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  output logic                  fetch_starved
);

  logic [3:0]         starve_cnt;
  logic               starved;
  logic [LATENCY-1:0] tag_v;
  logic [LATENCY-1:0] tag_o;
  logic               rd_issue;
  logic               ret_v;
  logic               ret_o;
  logic [31:0]        fetch_hold;
  logic [31:0]        data_hold;

  assign starved = starve_cnt >= 4'(STARVE_LIMIT);

  // Loader always wins; a starved fetch jumps ahead of the data port.
  assign ldr_gnt   = rst & ldr_req;
  assign fetch_gnt = rst & fetch_req & ~ldr_req &
                     (starved | ~data_req);
  assign data_gnt  = rst & data_req & ~ldr_req &
                     ~(starved & fetch_req);

  assign fetch_starved = rst & fetch_req & starved;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (1'b1)
      ldr_gnt: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = ldr_addr[DEPTH_BITS-1:0];
        mem_wdata = ldr_wdata;
      end
      data_gnt: begin
        mem_en    = 1'b1;
        mem_we    = data_we;
        mem_addr  = data_addr[DEPTH_BITS-1:0];
        mem_wdata = data_wdata;
      end
      fetch_gnt: begin
        mem_en   = 1'b1;
        mem_addr = fetch_addr[DEPTH_BITS-1:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (fetch_req && !fetch_gnt) begin
      if (starve_cnt != 4'hf) starve_cnt <= starve_cnt + 4'd1;
    end else begin
      starve_cnt <= '0;
    end
  end

  // Tag pipeline: owner 1 = data port, 0 = fetch.
  assign rd_issue = fetch_gnt | (data_gnt & ~data_we);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_v <= '0;
      tag_o <= '0;
    end else begin
      tag_v[0] <= rd_issue;
      tag_o[0] <= data_gnt;
      for (int i = 1; i < LATENCY; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_o[i] <= tag_o[i-1];
      end
    end
  end

  assign ret_v = tag_v[LATENCY-1];
  assign ret_o = tag_o[LATENCY-1];

  assign fetch_rvalid = ret_v & ~ret_o;
  assign data_rvalid  = ret_v & ret_o;

  // Memory data passes straight through on return, then is held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_hold <= '0;
      data_hold  <= '0;
    end else begin
      if (fetch_rvalid) fetch_hold <= mem_rdata;
      if (data_rvalid)  data_hold  <= mem_rdata;
    end
  end

  assign fetch_rdata = fetch_rvalid ? mem_rdata : fetch_hold;
  assign data_rdata  = data_rvalid  ? mem_rdata : data_hold;

  generate
    if (DEPTH_BITS < 32) begin : g_unused
      logic unused_hi;
      assign unused_hi = ^{fetch_addr[31:DEPTH_BITS],
                           data_addr[31:DEPTH_BITS],
                           ldr_addr[31:DEPTH_BITS]};
    end
  endgenerate

endmodule

// File: tb/tb_main_mem_port_arbiter.sv
// Self-checking bench for main_mem_port_arbiter.
// Two instances (LATENCY 1 and 3) share stimulus; a scoreboard checks returns.
module tb_main_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req, data_req, data_we, ldr_req;
  logic [31:0] fetch_addr, data_addr, data_wdata, ldr_addr, ldr_wdata;

  logic        fg[2], frv[2], dg[2], drv[2], lg[2];
  logic        men[2], mwe[2], fst[2];
  logic [31:0] frd[2], drd[2], mwd[2], mrd[2];
  logic [10:0] ma[2];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int          inst;
    int          cyc;
    bit          own;
    logic [31:0] d;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] f(logic [10:0] a);
    return 32'hDEADBEEF ^ (({21'd0, a} ^ 32'h10) << 8);
  endfunction

  for (genvar i = 0; i < 2; i++) begin : g_dut
    main_mem_port_arbiter #(
      .LATENCY(i == 0 ? 1 : 3),
      .STARVE_LIMIT(4),
      .DEPTH_BITS(11)
    ) dut (
      .clk(clk), .rst(rst),
      .fetch_req(fetch_req), .fetch_addr(fetch_addr),
      .fetch_gnt(fg[i]), .fetch_rvalid(frv[i]), .fetch_rdata(frd[i]),
      .data_req(data_req), .data_we(data_we),
      .data_addr(data_addr), .data_wdata(data_wdata),
      .data_gnt(dg[i]), .data_rvalid(drv[i]), .data_rdata(drd[i]),
      .ldr_req(ldr_req), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
      .ldr_gnt(lg[i]),
      .mem_en(men[i]), .mem_we(mwe[i]), .mem_addr(ma[i]),
      .mem_wdata(mwd[i]), .mem_rdata(mrd[i]),
      .fetch_starved(fst[i])
    );
  end

  // Memory models: read data is a known function of the address.
  logic [10:0] rpa;
  logic [10:0] rpb[3];
  always @(posedge clk) begin
    rpa    <= ma[0];
    rpb[0] <= ma[1];
    rpb[1] <= rpb[0];
    rpb[2] <= rpb[1];
  end
  assign mrd[0] = f(rpa);
  assign mrd[1] = f(rpb[2]);

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic push(bit own, logic [10:0] a);
    q.push_back('{0, cyc + 1, own, f(a)});
    q.push_back('{1, cyc + 3, own, f(a)});
  endtask

  task automatic drive();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic idle();
    fetch_req = 1'b0;
    data_req  = 1'b0;
    data_we   = 1'b0;
    ldr_req   = 1'b0;
  endtask

  task automatic chk_gnt(string tag, logic [2:0] e);
    for (int i = 0; i < 2; i++)
      chk(tag, {fg[i], dg[i], lg[i]}, e);
  endtask

  task automatic chk_rst(string tag);
    for (int i = 0; i < 2; i++) begin
      chk({tag, "_flags"},
          {fg[i], dg[i], lg[i], men[i], mwe[i],
           frv[i], drv[i], fst[i]}, 0);
      chk({tag, "_frd"}, frd[i], 0);
      chk({tag, "_drd"}, drd[i], 0);
      chk({tag, "_addr"}, ma[i], 0);
      chk({tag, "_wdata"}, mwd[i], 0);
    end
  endtask

  // Scoreboard: every rvalid must match the oldest pending read.
  always @(negedge clk) begin
    int   idx[$];
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      if (frv[i] === 1'b1 || drv[i] === 1'b1) begin
        idx = q.find_first_index(x) with (x.inst == i);
        chk("rv_expected", 32'(idx.size() != 0), 1);
        if (idx.size() != 0) begin
          e = q[idx[0]];
          q.delete(idx[0]);
          chk("rv_cycle", cyc, e.cyc);
          chk("rv_owner", {frv[i], drv[i]},
              e.own ? 2'b01 : 2'b10);
          chk("rv_data", e.own ? drd[i] : frd[i], e.d);
        end
      end
    end
  end

  initial begin
    rst = 1'b0;
    idle();
    fetch_addr = '0;
    data_addr  = '0;
    data_wdata = '0;
    ldr_addr   = '0;
    ldr_wdata  = '0;
    repeat (2) drive();
    samp();
    chk_rst("reset");
    drive();
    rst = 1'b1;

    // Single fetch
    drive();
    fetch_req  = 1'b1;
    fetch_addr = 32'h10;
    push(1'b0, 11'h10);
    samp();
    chk_gnt("f1_gnt", 3'b100);
    chk("f1_addr", ma[0], 11'h10);
    chk("f1_en", {men[0], mwe[0]}, 2'b10);
    drive();
    idle();
    samp();
    chk("f1_rv", {frv[0], drv[0]}, 2'b10);
    chk("f1_rd", frd[0], 32'hDEADBEEF);
    repeat (3) drive();

    // All three requesting: loader wins
    fetch_req  = 1'b1;
    fetch_addr = 32'h44;
    data_req   = 1'b1;
    data_addr  = 32'h48;
    ldr_req    = 1'b1;
    ldr_addr   = 32'h20;
    ldr_wdata  = 32'h5;
    samp();
    chk_gnt("all_gnt", 3'b001);
    chk("all_we", mwe[0], 1'b1);
    chk("all_wd", mwd[0], 32'h5);
    chk("all_addr", ma[1], 11'h20);
    chk("all_hold", frd[0], 32'hDEADBEEF);
    drive();
    idle();
    samp();
    chk("all_norv", {frv[0], drv[0]}, 2'b00);

    // Starvation: data wins 4 cycles, then fetch once
    for (int k = 0; k < 8; k++) begin
      drive();
      fetch_req  = 1'b1;
      fetch_addr = 32'h100;
      data_req   = 1'b1;
      data_we    = 1'b0;
      data_addr  = 32'h200 + 32'(k * 4);
      if (k == 4) push(1'b0, 11'h100);
      else push(1'b1, 11'(32'h200 + k * 4));
      samp();
      chk_gnt("stv_gnt", (k == 4) ? 3'b100 : 3'b010);
      chk("stv_flag", fst[0], (k == 4) ? 1'b1 : 1'b0);
      chk("stv_flag_b", fst[1], (k == 4) ? 1'b1 : 1'b0);
    end
    drive();
    idle();
    repeat (4) drive();

    // Back-to-back load then fetch
    data_req  = 1'b1;
    data_addr = 32'h30;
    push(1'b1, 11'h30);
    samp();
    chk_gnt("b2b_ld", 3'b010);
    drive();
    data_req   = 1'b0;
    fetch_req  = 1'b1;
    fetch_addr = 32'h40;
    push(1'b0, 11'h40);
    samp();
    chk_gnt("b2b_f", 3'b100);
    drive();
    idle();
    repeat (4) drive();

    // Store
    data_req   = 1'b1;
    data_we    = 1'b1;
    data_addr  = 32'h8;
    data_wdata = 32'h77;
    samp();
    chk_gnt("st_gnt", 3'b010);
    chk("st_we", mwe[0], 1'b1);
    chk("st_addr", ma[0], 11'h8);
    chk("st_wd", mwd[1], 32'h77);
    drive();
    idle();
    repeat (4) drive();

    // Load killed by reset before its return
    data_req  = 1'b1;
    data_we   = 1'b0;
    data_addr = 32'h60;
    samp();
    chk_gnt("rl_gnt", 3'b010);
    #1;
    rst       = 1'b0;
    data_req  = 1'b0;
    fetch_req = 1'b1;
    #1;
    chk_rst("rl_hold1");
    drive();
    chk_rst("rl_hold2");
    samp();
    #1;
    rst       = 1'b1;
    fetch_req = 1'b0;
    drive();
    fetch_req  = 1'b1;
    fetch_addr = 32'h0001_2345;
    push(1'b0, 11'h345);
    samp();
    chk_gnt("post_gnt", 3'b100);
    chk("post_addr", ma[0], 11'h345);
    drive();
    idle();
    repeat (6) drive();
    chk("q_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/main_mem_port_arbiter.md
Name: main_mem_port_arbiter

Overview:
- Shares the single synchronous main-memory port between three requesters: instruction fetch (read-only), the memory stage (load/store), and the program loader/debug port (write-only).
- Issues at most one access per cycle and tracks in-flight reads so each returns to the requester that issued it.
- Guarantees fetch forward progress under back-to-back load/store traffic with a starvation counter.
- Sits between the fetch/memory pipeline stages and the main memory instance.

Parameters:
- LATENCY, 1: cycles from the cycle mem_en is asserted to the cycle mem_rdata is valid. Legal range 1..4.
- STARVE_LIMIT, 4: number of consecutive denied fetch-request cycles after which fetch beats the data port. Legal range 1..15.
- DEPTH_BITS, 11: memory address bits actually driven. Upper address bits are ignored.

Ports:
- clk, input, 1: clock.
- rst, input, 1: asynchronous, active-low reset.
- fetch_req, input, 1: fetch read request.
- fetch_addr, input, 32: fetch word address.
- fetch_gnt, output, 1: fetch request accepted this cycle.
- fetch_rvalid, output, 1: fetch_rdata valid.
- fetch_rdata, output, 32: fetch read data.
- data_req, input, 1: memory-stage request.
- data_we, input, 1: 1 = store, 0 = load.
- data_addr, input, 32: load/store address.
- data_wdata, input, 32: store data.
- data_gnt, output, 1: data request accepted this cycle.
- data_rvalid, output, 1: data_rdata valid (loads only).
- data_rdata, output, 32: load data.
- ldr_req, input, 1: loader write request.
- ldr_addr, input, 32: loader address.
- ldr_wdata, input, 32: loader data.
- ldr_gnt, output, 1: loader write accepted this cycle.
- mem_en, output, 1: memory access this cycle.
- mem_we, output, 1: memory write enable.
- mem_addr, output, DEPTH_BITS: memory address, taken from addr[DEPTH_BITS-1:0].
- mem_wdata, output, 32: memory write data.
- mem_rdata, input, 32: memory read data.
- fetch_starved, output, 1: starvation override active this cycle.

Behaviour:
- Grants:
  - Combinational from the current requests and registered state.
  - At most one of fetch_gnt, data_gnt, ldr_gnt is high in any cycle.
  - A grant implies mem_en=1 in the same cycle, with mem_addr, mem_we and mem_wdata taken from the winner.
- Priority, base order: ldr > data > fetch.
- Starvation override:
  - starve_cnt is a 4-bit register. It increments, saturating at 15, in each cycle where fetch_req=1 and fetch_gnt=0.
  - It clears in any cycle where fetch_gnt=1 or fetch_req=0.
  - When starve_cnt >= STARVE_LIMIT, fetch wins over data, but never over ldr. fetch_starved=1 in such cycles.
- Requester handshake: req and its addr/wdata must stay stable until gnt. Deasserting req before gnt is legal and simply withdraws the request.
- Write semantics:
  - Writes (data_we=1, or any ldr access) return no rvalid.
  - Fetch is always a read.
- Read return:
  - A LATENCY-deep shift register carries {valid, owner} for each issued read.
  - Exactly LATENCY cycles after the grant, the owner's rvalid pulses for one cycle and its rdata equals mem_rdata. The other rdata output holds its last value.
  - Reads to different owners may be interleaved back to back, one per cycle. Returns keep issue order.
- Pipelining: a new grant may issue every cycle, independent of reads still in flight. No internal buffering of requests.
- Simultaneous events: a read return and a new grant in the same cycle are independent and both occur.
- Idle cycle: no request pending gives mem_en=0, mem_we=0, all gnt=0, and the shift-register entry for that cycle is invalid.
- Reset (asynchronous, active-low):
  - Values while held: starve_cnt=0, tag pipeline all invalid, fetch_rvalid=0, data_rvalid=0, fetch_rdata=0, data_rdata=0, fetch_starved=0.
  - Grants and mem_en are forced to 0 while rst=0.
  - Reset mid-operation discards all in-flight reads: no rvalid after rst deasserts for accesses issued before it.
- Outputs mem_addr and mem_wdata equal 0 when mem_en=0.

Test Plan:
- Reset, then fetch_req=1 with fetch_addr=0x10 and mem_rdata=0xDEADBEEF at the return edge (LATENCY=1) -> fetch_gnt same cycle, mem_addr=0x10, fetch_rvalid=1 with fetch_rdata=0xDEADBEEF one cycle later; data_rvalid stays 0.
- All three requesting in one cycle, ldr_addr=0x20, ldr_wdata=0x5 -> only ldr_gnt=1, mem_we=1, mem_wdata=0x5; neither rvalid pulses one cycle later.
- fetch_req and data_req (load) held high for 8 cycles, STARVE_LIMIT=4 -> data_gnt in cycles 0-3, fetch_gnt and fetch_starved=1 in cycle 4, data_gnt resumes in cycle 5; starve_cnt returns to 0 after cycle 4.
- Back-to-back data load to 0x30 then fetch to 0x40, LATENCY=3 -> data_rvalid 3 cycles after the first grant, fetch_rvalid in the following cycle, each carrying the corresponding mem_rdata.
- Store via data_we=1, addr 0x8, wdata 0x77 -> data_gnt, mem_we=1, mem_addr=0x8, no data_rvalid.
- Load granted, rst pulsed low for 1 cycle before its return -> no data_rvalid; all outputs 0 during reset; next fetch after reset returns normally.
